ram_256x8: RTL and testbench
============================

RAM_256X8 -- requirements
Module: ram_256x8

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port MOV, input, 1 bit: memory-operation request.
REQ-004 SHALL have port ReadWrite, input, 1 bit: 1 = read, 0 = write.
REQ-005 SHALL have port MS_2_0, input, 3 bits: [1:0] size (00 byte, 01 halfword, 10 word, 11 treated as word); [2] signed-read flag.
REQ-006 SHALL have port DataIn, input, 32 bits: write data, right-justified.
REQ-007 SHALL have port Address, input, 32 bits: byte address; only [7:0] used, [31:8] ignored.
REQ-008 SHALL have port MOC, output, 1 bit: memory-operation-complete.
REQ-009 SHALL have port DataOut, output, 32 bits: read data, right-justified.

Function
REQ-010 SHALL store 256 bytes, byte-addressable, no alignment restriction.
REQ-011 SHALL use big-endian order: byte at A is most significant, then A+1, A+2, A+3.
REQ-012 SHALL compute multi-byte addresses modulo 256 (word at 8'hFE uses FE, FF, 00, 01).
REQ-013 SHALL start an operation on a rising edge where MOV=1 and MOC=0; at that same edge it SHALL perform the access and register MOC=1.
REQ-014 SHALL hold MOC=1 while MOV=1 without repeating the operation; it SHALL clear MOC at the first rising edge with MOV=0 (4-phase handshake, 1-cycle latency).
REQ-015 On a read, SHALL load DataOut at the start edge: byte into [7:0], halfword into [15:0], word into [31:0]; upper bits per REQ-024.
REQ-016 On a write, SHALL store DataIn[7:0], DataIn[15:0] or DataIn[31:0] per the size, big-endian; other bytes SHALL be unchanged.
REQ-017 A write SHALL leave DataOut unchanged.
REQ-018 SHALL sample Address, MS_2_0, ReadWrite and DataIn only at the start edge; later changes SHALL have no effect until the next operation.
REQ-019 Memory contents SHALL be undefined at power-up and SHALL be pre-loadable by simulation hierarchical assignment to the array (REQ-027).

Reset
REQ-020 RST_N=0 SHALL immediately force MOC=0 and DataOut=32'h0, independent of CLK.
REQ-021 Reset SHALL NOT clear memory contents.
REQ-022 Reset during an active handshake SHALL abort it; after release, a new operation SHALL start only at an edge with MOV=1.

Configuration
REQ-023 SHALL use macro RAM_256X8_SIGN_EXT_EN.
REQ-024 With the macro defined, a read with MS_2_0[2]=1 SHALL sign-extend a byte or halfword to 32 bits; MS_2_0[2]=0 SHALL zero-extend. Without the macro, MS_2_0[2] SHALL be ignored and every read SHALL zero-extend.

Structure
REQ-025 Size encodings (BYTE=2'b00, HALF=2'b01, WORD=2'b10) and the memory depth (256) SHALL be defined in a shared package ram_256x8_pkg.
REQ-026 The top level SHALL hold the handshake/MOC logic.
REQ-027 The storage SHALL be in one sub-module, ram_256x8_core, instantiated as ram_256x8_c, containing the byte array named memory[0:255] and the endian/size datapath.

Verification
REQ-028 Preload bytes 0..3 = 85,12,34,56; byte read at address 0 (MS=000) -> DataOut=32'h00000085, MOC high one cycle after the start edge.
REQ-029 Same preload: halfword read (MS=001) -> 32'h00008512; word read (MS=010) -> 32'h85123456; with the macro, MS=100 -> 32'hFFFFFF85 and MS=101 -> 32'hFFFF8512.
REQ-030 Write byte 8'hAA at address 3, then word read at 0 -> 32'h851234AA; DataOut unchanged during the write.
REQ-031 Write halfword 16'h8181 at address 30 -> memory[30]=81, [31]=81; write word 32'hC0000001 at address 26 -> [26]=C0, [27]=00, [28]=00, [29]=01.
REQ-032 Word write 32'h11223344 at address 8'hFE -> memory[FE]=11, [FF]=22, [00]=33, [01]=44; MOV held high 5 cycles -> one write only, MOC stays 1 until MOV=0.
REQ-033 RST_N pulsed low while MOC=1 -> MOC=0 and DataOut=0 immediately; memory contents preserved.

Source files
------------

// File: rtl/ram_256x8_pkg.sv
// ram_256x8_pkg
// Shared definitions for the 256 x 8 byte-addressable RAM:
//   - access-size encodings carried on MS_2_0[1:0]
//   - memory depth and address width
// Imported by ram_256x8 (top) and ram_256x8_core (storage/datapath).

package ram_256x8_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    // 2'b11 is not listed; the datapath treats it as a word access.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

endpackage

// File: rtl/ram_256x8_core.sv
// ram_256x8_core
// Byte array plus the big-endian size/endian datapath.
// Optional feature macro: RAM_256X8_SIGN_EXT_EN (sign-extension of byte and
// halfword reads when sign_rd=1). Without it, every read is zero-extended.
//
// Ports
//   CLK      in   clock, writes commit on rising edge
//   wr_en    in   write strobe, one cycle per write operation
//   addr     in   8-bit byte address of the most significant byte
//   size     in   access size (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 = word)
//   sign_rd  in   signed-read request
//   wr_data  in   right-justified write data
//   rd_data  out  right-justified, extended read data (combinational)
//
// The array is deliberately not reset: contents survive RST_N and are
// undefined at power-up.

module ram_256x8_core
    import ram_256x8_pkg::*;
(
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              sign_rd,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);

    logic [7:0] memory [0:MEM_DEPTH-1];

    // 8-bit adds wrap naturally, giving modulo-256 addressing.
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] addr_p2;
    logic [ADDR_W-1:0] addr_p3;

    assign addr_p1 = addr + 8'd1;
    assign addr_p2 = addr + 8'd2;
    assign addr_p3 = addr + 8'd3;

    logic ext;
`ifdef RAM_256X8_SIGN_EXT_EN
    assign ext = sign_rd;
`else
    logic sign_rd_unused;
    assign sign_rd_unused = sign_rd;
    assign ext            = 1'b0;
`endif

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;

    always_comb begin
        b0      = memory[addr];
        b1      = memory[addr_p1];
        b2      = memory[addr_p2];
        b3      = memory[addr_p3];
        rd_data = {b0, b1, b2, b3};
        case (size)
            SZ_BYTE: rd_data = {{24{ext & b0[7]}}, b0};
            SZ_HALF: rd_data = {{16{ext & b0[7]}}, b0, b1};
            default: rd_data = {b0, b1, b2, b3};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            case (size)
                SZ_BYTE: begin
                    memory[addr] <= wr_data[7:0];
                end
                SZ_HALF: begin
                    memory[addr]    <= wr_data[15:8];
                    memory[addr_p1] <= wr_data[7:0];
                end
                default: begin
                    memory[addr]    <= wr_data[31:24];
                    memory[addr_p1] <= wr_data[23:16];
                    memory[addr_p2] <= wr_data[15:8];
                    memory[addr_p3] <= wr_data[7:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_256x8.sv
// ram_256x8
// 256 x 8 big-endian RAM with a 4-phase MOV/MOC handshake (1-cycle latency).
// Optional feature macro: RAM_256X8_SIGN_EXT_EN (see ram_256x8_core).
//
// Ports
//   CLK        in   clock, all state changes on rising edge
//   RST_N      in   async active-low reset (clears MOC/DataOut, not memory)
//   MOV        in   memory-operation request
//   ReadWrite  in   1 = read, 0 = write
//   MS_2_0     in   [1:0] size, [2] signed read
//   DataIn     in   right-justified write data
//   Address    in   byte address, only [7:0] used
//   MOC        out  memory-operation complete
//   DataOut    out  right-justified read data

module ram_256x8
    import ram_256x8_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MOV,
    input  logic        ReadWrite,
    input  logic [2:0]  MS_2_0,
    input  logic [31:0] DataIn,
    input  logic [31:0] Address,
    output logic        MOC,
    output logic [31:0] DataOut
);

    logic        start;
    logic        wr_en;
    logic [31:0] rd_data;
    logic [23:0] addr_hi_unused;

    assign addr_hi_unused = Address[31:8];

    // An operation starts only while MOC is low; holding MOV afterwards
    // keeps MOC up without re-triggering the access.
    assign start = MOV & ~MOC;
    // Gate with RST_N so no write can land while reset is asserted.
    assign wr_en = start & ~ReadWrite & RST_N;

    ram_256x8_core ram_256x8_c (
        .CLK     (CLK),
        .wr_en   (wr_en),
        .addr    (Address[ADDR_W-1:0]),
        .size    (MS_2_0[1:0]),
        .sign_rd (MS_2_0[2]),
        .wr_data (DataIn),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MOC     <= 1'b0;
            DataOut <= 32'h0;
        end else if (start) begin
            MOC <= 1'b1;
            if (ReadWrite) begin
                DataOut <= rd_data;
            end
        end else if (!MOV) begin
            MOC <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_256x8.sv
module tb_ram_256x8;

    logic        CLK;
    logic        RST_N;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] DataIn;
    logic [31:0] Address;
    logic        MOC;
    logic [31:0] DataOut;

    int checks;
    int failures;

`ifdef RAM_256X8_SIGN_EXT_EN
    localparam bit SIGN_EXT = 1'b1;
`else
    localparam bit SIGN_EXT = 1'b0;
`endif

    ram_256x8 dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MOV       (MOV),
        .ReadWrite (ReadWrite),
        .MS_2_0    (MS_2_0),
        .DataIn    (DataIn),
        .Address   (Address),
        .MOC       (MOC),
        .DataOut   (DataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic rw, input logic [2:0] ms,
                            input logic [31:0] addr, input logic [31:0] din);
        @(negedge CLK);
        ReadWrite = rw;
        MS_2_0    = ms;
        Address   = addr;
        DataIn    = din;
        MOV       = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic end_op(input string tag);
        @(negedge CLK);
        MOV = 1'b0;
        @(posedge CLK);
        #1;
        check_val({tag, "_moc_clr"}, {31'd0, MOC}, 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [2:0] ms,
                            input logic [31:0] addr, input logic [31:0] exp);
        start_op(1'b1, ms, addr, 32'hDEAD_BEEF);
        check_val({tag, "_moc"}, {31'd0, MOC}, 32'd1);
        check_val({tag, "_data"}, DataOut, exp);
        end_op(tag);
    endtask

    task automatic write_op(input string tag, input logic [2:0] ms, input logic [31:0] addr,
                            input logic [31:0] din, input logic [31:0] exp_dout);
        start_op(1'b0, ms, addr, din);
        check_val({tag, "_moc"}, {31'd0, MOC}, 32'd1);
        check_val({tag, "_dout_hold"}, DataOut, exp_dout);
        end_op(tag);
    endtask

    function automatic logic [31:0] mem_at(input logic [7:0] a);
        return {24'd0, dut.ram_256x8_c.memory[a]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        RST_N     = 1'b0;
        MOV       = 1'b0;
        ReadWrite = 1'b1;
        MS_2_0    = 3'b000;
        DataIn    = 32'h0;
        Address   = 32'h0;
        #1;
        dut.ram_256x8_c.memory[0]     = 8'h85;
        dut.ram_256x8_c.memory[1]     = 8'h12;
        dut.ram_256x8_c.memory[2]     = 8'h34;
        dut.ram_256x8_c.memory[3]     = 8'h56;
        dut.ram_256x8_c.memory[8'h10] = 8'h5A;
        #1;
        check_val("rst_moc", {31'd0, MOC}, 32'd0);
        check_val("rst_dout", DataOut, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // reads of preloaded bytes
        read_chk("rd_byte", 3'b000, 32'h0, 32'h0000_0085);
        read_chk("rd_half", 3'b001, 32'h0, 32'h0000_8512);
        read_chk("rd_word", 3'b010, 32'h0, 32'h8512_3456);
        read_chk("rd_sz11", 3'b011, 32'h0, 32'h8512_3456);
        read_chk("rd_sbyte", 3'b100, 32'h0, SIGN_EXT ? 32'hFFFF_FF85 : 32'h0000_0085);
        read_chk("rd_shalf", 3'b101, 32'h0, SIGN_EXT ? 32'hFFFF_8512 : 32'h0000_8512);
        read_chk("rd_sword", 3'b110, 32'h0, 32'h8512_3456);
        read_chk("rd_hiaddr", 3'b000, 32'hFFFF_FF01, 32'h0000_0012);
        read_chk("rd_spos", 3'b101, 32'h1, 32'h0000_1234);

        // byte write leaves DataOut alone
        write_op("wr_byte", 3'b000, 32'h3, 32'hFFFF_FFAA, 32'h0000_1234);
        read_chk("rd_after_b", 3'b010, 32'h0, 32'h8512_34AA);

        // halfword and word writes
        write_op("wr_half", 3'b001, 32'd30, 32'h0000_8181, 32'h8512_34AA);
        check_val("m30", mem_at(8'd30), 32'h81);
        check_val("m31", mem_at(8'd31), 32'h81);
        write_op("wr_word", 3'b010, 32'd26, 32'hC000_0001, 32'h8512_34AA);
        check_val("m26", mem_at(8'd26), 32'hC0);
        check_val("m27", mem_at(8'd27), 32'h00);
        check_val("m28", mem_at(8'd28), 32'h00);
        check_val("m29", mem_at(8'd29), 32'h01);
        read_chk("rd_28", 3'b010, 32'd28, 32'h0001_8181);

        // wrapping word write with MOV held 5 cycles and inputs changed mid-handshake
        start_op(1'b0, 3'b010, 32'h0000_00FE, 32'h1122_3344);
        check_val("wrap_moc0", {31'd0, MOC}, 32'd1);
        Address = 32'h10;
        DataIn  = 32'h0;
        MS_2_0  = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            check_val("wrap_moc_hold", {31'd0, MOC}, 32'd1);
        end
        check_val("wrap_dout", DataOut, 32'h0001_8181);
        end_op("wrap");
        check_val("mFE", mem_at(8'hFE), 32'h11);
        check_val("mFF", mem_at(8'hFF), 32'h22);
        check_val("m00", mem_at(8'h00), 32'h33);
        check_val("m01", mem_at(8'h01), 32'h44);
        check_val("m10", mem_at(8'h10), 32'h5A);
        read_chk("rd_wrap", 3'b010, 32'hFE, 32'h1122_3344);
        read_chk("rd_0_after", 3'b010, 32'h0, 32'h3344_34AA);

        // async reset mid-handshake
        start_op(1'b1, 3'b010, 32'h0, 32'h0);
        check_val("prerst_moc", {31'd0, MOC}, 32'd1);
        check_val("prerst_dout", DataOut, 32'h3344_34AA);
        #2;
        RST_N = 1'b0;
        #1;
        check_val("arst_moc", {31'd0, MOC}, 32'd0);
        check_val("arst_dout", DataOut, 32'h0);
        @(negedge CLK);
        MOV = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_val("post_rst_moc", {31'd0, MOC}, 32'd0);
        check_val("post_rst_dout", DataOut, 32'h0);
        read_chk("rd_kept_fe", 3'b010, 32'hFE, 32'h1122_3344);
        read_chk("rd_kept_0", 3'b010, 32'h0, 32'h3344_34AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
